// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: optional dirty-victim writeback, line refill from
// main memory, then a single cache write cycle, with the pipeline frozen throughout.
module dcache_miss_ctrl #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  input  logic             cache_hit,
  input  logic             cache_dirty,
  input  logic [31:0]      victim_addr,
  output logic             lock,
  output logic [31:0]      mem_addr,
  output logic             mem_write_en,
  output logic             cache_we,
  output logic             cache_fill_sel,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             busy,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    FILL      = 2'd3
  } state_t;

  localparam logic [7:0] LAT_INIT = 8'(MEM_LATENCY - 1);

  state_t      state_r;
  logic [7:0]  lat_cnt_r;
  logic [31:0] addr_q_r;
  logic        miss_s;
  logic        unused_addr_bits_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (&val) begin
      return val;
    end else begin
      return val + CNT_W'(1);
    end
  endfunction

  assign unused_addr_bits_s = ^{req_addr[1:0], victim_addr[1:0]};

  // Miss detection is only meaningful while idle; the freeze must start in the detect cycle.
  always_comb begin
    miss_s = 1'b0;
    if (state_r == IDLE) begin
      miss_s = req_valid & ~cache_hit;
    end else begin
      miss_s = 1'b0;
    end
    lock = busy | miss_s;
  end

  // Miss sequencer state, memory strobes, cache-write strobes and counters.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_r        <= IDLE;
      lat_cnt_r      <= 8'd0;
      addr_q_r       <= 32'd0;
      mem_addr       <= 32'd0;
      mem_write_en   <= 1'b0;
      cache_we       <= 1'b0;
      cache_fill_sel <= 1'b0;
      set_valid      <= 1'b0;
      set_dirty      <= 1'b0;
      busy           <= 1'b0;
      miss_count     <= '0;
      wb_count       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cache_we       <= 1'b0;
          cache_fill_sel <= 1'b0;
          set_valid      <= 1'b0;
          set_dirty      <= 1'b0;
          if (miss_s) begin
            addr_q_r   <= {req_addr[31:2], 2'b00};
            lat_cnt_r  <= LAT_INIT;
            miss_count <= sat_inc(miss_count);
            busy       <= 1'b1;
            if (cache_dirty) begin
              state_r      <= WRITEBACK;
              mem_addr     <= {victim_addr[31:2], 2'b00};
              mem_write_en <= 1'b1;
              wb_count     <= sat_inc(wb_count);
            end else begin
              state_r      <= REFILL;
              mem_addr     <= {req_addr[31:2], 2'b00};
              mem_write_en <= 1'b0;
            end
          end else begin
            state_r      <= IDLE;
            mem_write_en <= 1'b0;
            busy         <= 1'b0;
          end
        end

        WRITEBACK: begin
          if (lat_cnt_r == 8'd0) begin
            state_r      <= REFILL;
            mem_write_en <= 1'b0;
            mem_addr     <= addr_q_r;
            lat_cnt_r    <= LAT_INIT;
          end else begin
            lat_cnt_r    <= lat_cnt_r - 8'd1;
          end
        end

        REFILL: begin
          mem_write_en <= 1'b0;
          if (lat_cnt_r == 8'd0) begin
            state_r        <= FILL;
            cache_we       <= 1'b1;
            cache_fill_sel <= 1'b1;
            set_valid      <= 1'b1;
            set_dirty      <= 1'b0;
          end else begin
            lat_cnt_r      <= lat_cnt_r - 8'd1;
          end
        end

        FILL: begin
          state_r        <= IDLE;
          cache_we       <= 1'b0;
          cache_fill_sel <= 1'b0;
          set_valid      <= 1'b0;
          set_dirty      <= 1'b0;
          mem_write_en   <= 1'b0;
          busy           <= 1'b0;
        end

        default: begin
          state_r        <= IDLE;
          lat_cnt_r      <= 8'd0;
          cache_we       <= 1'b0;
          cache_fill_sel <= 1'b0;
          set_valid      <= 1'b0;
          set_dirty      <= 1'b0;
          mem_write_en   <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: a MEM_LATENCY=4/CNT_W=2 instance is fully
// checked, a MEM_LATENCY=1 instance on the same inputs checks the short-latency timing.
module tb_dcache_miss_ctrl;

  localparam int LAT = 4;

  typedef struct {
    logic        dirty;
    logic [31:0] wb_addr;
    logic [31:0] rd_addr;
    int          lock_len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        cache_hit;
  logic        cache_dirty;
  logic [31:0] victim_addr;

  logic        lock, mem_write_en, cache_we, cache_fill_sel, set_valid, set_dirty, busy;
  logic [31:0] mem_addr;
  logic [1:0]  miss_count, wb_count;

  logic        lock1, mem_write_en1, cache_we1, cache_fill_sel1, set_valid1, set_dirty1, busy1;
  logic [31:0] mem_addr1;
  logic [15:0] miss_count1, wb_count1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  int lock_len = 0, wr_cyc = 0, wr_ok = 0, rd_cyc = 0, rd_ok = 0;
  int lock1_cnt = 0, wr1_cnt = 0, we1_cnt = 0;

  dcache_miss_ctrl #(.MEM_LATENCY(LAT), .CNT_W(2)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_addr(req_addr),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty), .victim_addr(victim_addr),
    .lock(lock), .mem_addr(mem_addr), .mem_write_en(mem_write_en), .cache_we(cache_we),
    .cache_fill_sel(cache_fill_sel), .set_valid(set_valid), .set_dirty(set_dirty),
    .busy(busy), .miss_count(miss_count), .wb_count(wb_count)
  );

  dcache_miss_ctrl #(.MEM_LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_addr(req_addr),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty), .victim_addr(victim_addr),
    .lock(lock1), .mem_addr(mem_addr1), .mem_write_en(mem_write_en1), .cache_we(cache_we1),
    .cache_fill_sel(cache_fill_sel1), .set_valid(set_valid1), .set_dirty(set_dirty1),
    .busy(busy1), .miss_count(miss_count1), .wb_count(wb_count1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one miss for a single detect cycle and queue what the sequence must look like.
  task automatic do_miss(input logic [31:0] addr, input logic dirty, input logic [31:0] victim);
    exp_t e;
    @(posedge clk); #1;
    req_valid   = 1'b1;
    cache_hit   = 1'b0;
    req_addr    = addr;
    cache_dirty = dirty;
    victim_addr = victim;
    e.dirty    = dirty;
    e.wb_addr  = victim & 32'hFFFF_FFFC;
    e.rd_addr  = addr & 32'hFFFF_FFFC;
    e.lock_len = dirty ? (2 * LAT + 2) : (LAT + 2);
    sb_q.push_back(e);
    @(negedge clk);
    check_eq("detect_lock", {31'd0, lock}, 32'd1);
    check_eq("detect_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_fill();
    logic seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (cache_we) seen = 1'b1;
    end
    if (!seen) check_eq("fill_timeout", {31'd0, cache_we}, 32'd1);
  endtask

  // Monitor: accumulate one miss sequence and compare it against the queued expectation at FILL.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        lock_len = 0; wr_cyc = 0; wr_ok = 0; rd_cyc = 0; rd_ok = 0;
      end else begin
        if (lock) lock_len++;
        if (mem_write_en) begin
          wr_cyc++;
          if (sb_q.size() > 0 && mem_addr == sb_q[0].wb_addr) wr_ok++;
        end
        if (busy && !mem_write_en && !cache_we) begin
          rd_cyc++;
          if (sb_q.size() > 0 && mem_addr == sb_q[0].rd_addr) rd_ok++;
        end
        if (cache_we) begin
          check_eq("fill_pending", {31'd0, sb_q.size() != 0}, 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("lock_len", lock_len, e.lock_len);
            check_eq("wb_cycles", wr_cyc, e.dirty ? LAT : 0);
            check_eq("wb_addr_ok", wr_ok, e.dirty ? LAT : 0);
            check_eq("refill_cycles", rd_cyc, LAT);
            check_eq("refill_addr_ok", rd_ok, LAT);
            check_eq("fill_sel", {31'd0, cache_fill_sel}, 32'd1);
            check_eq("set_valid", {31'd0, set_valid}, 32'd1);
            check_eq("set_dirty", {31'd0, set_dirty}, 32'd0);
          end
          lock_len = 0; wr_cyc = 0; wr_ok = 0; rd_cyc = 0; rd_ok = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (lock1) lock1_cnt++;
      if (mem_write_en1) wr1_cnt++;
      if (cache_we1) we1_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, w0, c0;
    int n_miss;
    rst_b = 1'b1; req_valid = 1'b0; req_addr = 32'd0; cache_hit = 1'b0;
    cache_dirty = 1'b0; victim_addr = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_lock", {31'd0, lock}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_wen", {31'd0, mem_write_en}, 32'd0);
    check_eq("rst_cache_we", {31'd0, cache_we}, 32'd0);
    check_eq("rst_miss_count", {30'd0, miss_count}, 32'd0);
    rst_b = 1'b0;

    // Hits never lock or touch memory.
    @(posedge clk); #1;
    req_valid = 1'b1; cache_hit = 1'b1; req_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("hit_lock", {31'd0, lock}, 32'd0);
      check_eq("hit_wen", {31'd0, mem_write_en}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("hit_miss_count", {30'd0, miss_count}, 32'd0);

    do_miss(32'h203, 1'b0, 32'h0);
    wait_fill();
    check_eq("clean_miss_count", {30'd0, miss_count}, 32'd1);
    check_eq("clean_wb_count", {30'd0, wb_count}, 32'd0);

    do_miss(32'h0200, 1'b1, 32'h1200);
    wait_fill();
    check_eq("dirty_miss_count", {30'd0, miss_count}, 32'd2);
    check_eq("dirty_wb_count", {30'd0, wb_count}, 32'd1);
    @(negedge clk);
    check_eq("post_fill_we", {31'd0, cache_we}, 32'd0);
    check_eq("post_fill_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the second writeback cycle.
    do_miss(32'h0400, 1'b1, 32'h2400);
    @(posedge clk); #1;
    rst_b = 1'b1;
    #1;
    check_eq("rstmid_lock", {31'd0, lock}, 32'd0);
    check_eq("rstmid_wen", {31'd0, mem_write_en}, 32'd0);
    check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
    check_eq("rstmid_miss_count", {30'd0, miss_count}, 32'd0);
    check_eq("rstmid_wb_count", {30'd0, wb_count}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    c0 = we1_cnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("rstmid_no_fill", {31'd0, cache_we}, 32'd0);
    end
    check_eq("rstmid_no_fill1", we1_cnt - c0, 0);

    // Back-to-back: a new miss in the cycle right after FILL.
    do_miss(32'h0500, 1'b0, 32'h0);
    wait_fill();
    do_miss(32'h300, 1'b0, 32'h0);
    wait_fill();
    check_eq("b2b_miss_count", {30'd0, miss_count}, 32'd2);
    n_miss = 2;

    for (int k = 0; k < 3; k++) begin
      do_miss(32'h1000 + 32'(k * 16), 1'b0, 32'h0);
      wait_fill();
      n_miss++;
      check_eq("sat_miss_count", {30'd0, miss_count}, (n_miss > 3) ? 32'd3 : 32'(n_miss));
    end

    // MEM_LATENCY=1 instance: dirty then clean miss.
    l0 = lock1_cnt; w0 = wr1_cnt; c0 = we1_cnt;
    do_miss(32'h80, 1'b1, 32'h40);
    wait_fill();
    check_eq("lat1_dirty_lock", lock1_cnt - l0, 4);
    check_eq("lat1_dirty_wen", wr1_cnt - w0, 1);
    check_eq("lat1_dirty_we", we1_cnt - c0, 1);
    l0 = lock1_cnt; w0 = wr1_cnt; c0 = we1_cnt;
    do_miss(32'h84, 1'b0, 32'h0);
    wait_fill();
    check_eq("lat1_clean_lock", lock1_cnt - l0, 3);
    check_eq("lat1_clean_wen", wr1_cnt - w0, 0);
    check_eq("lat1_clean_we", we1_cnt - c0, 1);
    check_eq("lat1_miss_count", {16'd0, miss_count1}, 32'd7);
    check_eq("lat1_wb_count", {16'd0, wb_count1}, 32'd1);
    check_eq("sat_wb_count", {30'd0, wb_count}, 32'd1);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
Sequences the data-cache/main-memory datapath on a MEM-stage cache miss. On a miss it writes back a dirty victim if needed, refills the line from memory, and writes it into the cache. It holds the pipeline-wide lock for the whole sequence so the IF/ID/EX/MEM/WB buffers freeze. It sits beside the MEM stage and owns mem_addr/mem_write_en during miss handling.

Parameters:
MEM_LATENCY, 4, cycles main memory needs per word access (read or write); legal range 1..255
CNT_W, 16, width of the saturating miss and writeback counters

Ports:
clk  input  1  single clock, rising edge
rst_b  input  1  reset; asynchronous and active-high
req_valid  input  1  MEM stage holds a load/store (not nop, not halted)
req_addr  input  32  byte address of the MEM-stage access
cache_hit  input  1  cache tag match and valid for req_addr
cache_dirty  input  1  indexed line is valid and dirty
victim_addr  input  32  address of the line currently resident at req_addr's index
lock  output  1  pipeline freeze to all stage buffers
mem_addr  output  32  word-aligned memory address
mem_write_en  output  1  memory write strobe
cache_we  output  1  write the cache line this cycle
cache_fill_sel  output  1  1 = cache data input comes from mem_data_out
set_valid  output  1  valid bit written with cache_we
set_dirty  output  1  dirty bit written with cache_we
busy  output  1  FSM not in IDLE
miss_count  output  CNT_W  accepted misses, saturating
wb_count  output  CNT_W  dirty writebacks performed, saturating

Behaviour:
- States: IDLE, WRITEBACK, REFILL, FILL. A single down-counter lat_cnt (8 bits) times the memory states.
- Reset (asynchronous, rst_b=1), including mid-operation:
  - state=IDLE, lat_cnt=0.
  - mem_addr=0, mem_write_en=0, cache_we=0, cache_fill_sel=0, set_valid=0, set_dirty=0, busy=0.
  - miss_count=0, wb_count=0.
  - Any in-progress writeback/refill is abandoned with no partial cache write.
- miss = req_valid & ~cache_hit, evaluated only in IDLE.
- lock = busy | (state==IDLE & miss). This is combinational, so the pipeline freezes in the miss-detect cycle. All other outputs are registered.
- IDLE:
  - On a hit or ~req_valid: no action.
  - On miss: latch req_addr into addr_q, with bits [1:0] forced to 0.
  - On miss, the next state depends on cache_dirty:
    - cache_dirty=1: next state WRITEBACK; mem_addr <= {victim_addr[31:2],2'b00}, mem_write_en <= 1, wb_count += 1.
    - cache_dirty=0: next state REFILL; mem_addr <= addr_q value, mem_write_en <= 0.
  - In both cases lat_cnt <= MEM_LATENCY-1 and miss_count += 1.
- WRITEBACK:
  - mem_write_en held 1 and mem_addr held for exactly MEM_LATENCY cycles.
  - When lat_cnt==0: next state REFILL, mem_write_en <= 0, mem_addr <= addr_q, lat_cnt <= MEM_LATENCY-1.
- REFILL:
  - mem_write_en=0; mem_addr=addr_q for MEM_LATENCY cycles.
  - When lat_cnt==0: next state FILL, with cache_we, cache_fill_sel and set_valid <= 1 and set_dirty <= 0.
- FILL:
  - A single cycle with cache_we=1 and lock=1.
  - Next state IDLE; all strobes return to 0.
  - The access replays the next cycle as a hit. A store then sets dirty through the normal hit path, not through this block.
- Latency (lock high, detect cycle included): clean miss = MEM_LATENCY+2 cycles; dirty miss = 2*MEM_LATENCY+2 cycles.
- mem_addr holds its last value in IDLE. mem_write_en is never 1 outside WRITEBACK.
- Inputs other than rst_b are ignored outside IDLE; the sequence completes on the latched addr_q even if req_valid drops.
- A back-to-back miss on the cycle after FILL is accepted normally (IDLE-detect cycle).
- Counters saturate at all-ones and do not wrap.
- MEM_LATENCY=1: each memory state lasts exactly one cycle.

Test Plan:
- Hit: req_valid=1, cache_hit=1, addr 0x100 -> lock=0 every cycle, mem_write_en=0, miss_count stays 0.
- Clean miss, MEM_LATENCY=4, req_addr=0x203:
  - lock high 6 cycles; mem_addr=0x200 during REFILL; mem_write_en=0 throughout.
  - cache_we=1 exactly once with set_valid=1, set_dirty=0; miss_count=1.
- Dirty miss, victim_addr=0x1200, req_addr=0x0200:
  - mem_write_en=1 for 4 cycles at mem_addr 0x1200, then 4 cycles at 0x0200 with write_en=0, then the FILL cycle.
  - lock high 10 cycles; wb_count=1.
- Reset mid-WRITEBACK (assert rst_b in writeback cycle 2) -> same cycle: lock=0, mem_write_en=0, busy=0, counters=0; cache_we never asserts.
- Back-to-back: miss completes, next cycle a new miss at 0x300 -> accepted without a bubble; miss_count=2.
- Saturation with CNT_W=2: 5 clean misses -> miss_count=3.
